// File: rtl/seg7_pkg.sv
// Glyph constants shared by the seven-segment scan driver and its decoder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_pkg;

    // Segment order is {g,f,e,d,c,b,a}, active-high before any output inversion.
    localparam logic [6:0] GLYPH_0  = 7'h3F;
    localparam logic [6:0] GLYPH_1  = 7'h06;
    localparam logic [6:0] GLYPH_2  = 7'h5B;
    localparam logic [6:0] GLYPH_3  = 7'h4F;
    localparam logic [6:0] GLYPH_4  = 7'h66;
    localparam logic [6:0] GLYPH_5  = 7'h6D;
    localparam logic [6:0] GLYPH_6  = 7'h7D;
    localparam logic [6:0] GLYPH_7  = 7'h07;
    localparam logic [6:0] GLYPH_8  = 7'h7F;
    localparam logic [6:0] GLYPH_9  = 7'h6F;
    localparam logic [6:0] GLYPH_A  = 7'h77;
    localparam logic [6:0] GLYPH_B  = 7'h7C;
    localparam logic [6:0] GLYPH_C  = 7'h39;
    localparam logic [6:0] GLYPH_D  = 7'h5E;
    localparam logic [6:0] GLYPH_E  = 7'h79;
    localparam logic [6:0] GLYPH_F  = 7'h71;

    // Middle bar only: shown for non-decimal nibbles in decimal mode.
    localparam logic [6:0] SEG_DASH = 7'h40;
    // All segments dark.
    localparam logic [6:0] SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Nibble to seven-segment glyph, hex or decimal (10..15 as dash).
// Latency: combinational.
// Backpressure: none.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_mode,
    output logic [6:0] o_seg
);

    // Glyph lookup; decimal mode replaces the letter glyphs with a dash.
    always_comb begin
        o_seg = SEG_OFF;
        if (i_mode && (i_nibble > 4'd9)) begin
            o_seg = SEG_DASH;
        end else begin
            case (i_nibble)
                4'h0: o_seg = GLYPH_0;
                4'h1: o_seg = GLYPH_1;
                4'h2: o_seg = GLYPH_2;
                4'h3: o_seg = GLYPH_3;
                4'h4: o_seg = GLYPH_4;
                4'h5: o_seg = GLYPH_5;
                4'h6: o_seg = GLYPH_6;
                4'h7: o_seg = GLYPH_7;
                4'h8: o_seg = GLYPH_8;
                4'h9: o_seg = GLYPH_9;
                4'hA: o_seg = GLYPH_A;
                4'hB: o_seg = GLYPH_B;
                4'hC: o_seg = GLYPH_C;
                4'hD: o_seg = GLYPH_D;
                4'hE: o_seg = GLYPH_E;
                4'hF: o_seg = GLYPH_F;
            endcase
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: holds a digit word and scans one digit per slot.
// Latency: held-value load visible 2 cycles later; outputs registered 1 cycle after index.
// Backpressure: none; load is always accepted and the scan free-runs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 1000,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*N_DIGITS-1:0]   data_in,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     blank_in,
    input  logic                    mode,
    input  logic                    lzs,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an
);

    generate
        if ((N_DIGITS < 1) || (N_DIGITS > 8) || (REFRESH_DIV < 1)) begin : g_param_check
            $fatal(1, "seg7_scan_driver: N_DIGITS must be 1..8 and REFRESH_DIV must be >= 1");
        end
    endgenerate

    localparam int             CW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int             IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]  IDX_LAST = IW'(N_DIGITS - 1);
    // Inversion is applied only when writing the output registers.
    localparam logic           INV      = (ACTIVE_LOW != 0);

    logic [CW-1:0]           r_cnt;
    logic [IW-1:0]           r_idx;
    logic [4*N_DIGITS-1:0]   r_data;
    logic [N_DIGITS-1:0]     r_dp;
    logic [N_DIGITS-1:0]     r_blank;
    logic [6:0]              r_seg;
    logic                    r_dp_out;
    logic [N_DIGITS-1:0]     r_an;

    logic [N_DIGITS-1:0]     w_suppress;
    logic                    w_zero_above;
    logic [3:0]              w_nibble;
    logic                    w_dp_sel;
    logic                    w_blank_sel;
    logic [N_DIGITS-1:0]     w_an;
    logic [6:0]              w_seg;

    // Slot counter and digit index; index advances on the last cycle of each slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Held display word; reset wins over a simultaneous load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_dp    <= '0;
            r_blank <= '0;
        end else if (load) begin
            r_data  <= data_in;
            r_dp    <= dp_in;
            r_blank <= blank_in;
        end
    end

    // Leading-zero suppression: a digit is dark if it and every digit above it are zero; digit 0 never.
    always_comb begin
        w_zero_above = 1'b1;
        w_suppress   = '0;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            w_zero_above  = w_zero_above & (r_data[4*i +: 4] == 4'd0);
            w_suppress[i] = lzs & w_zero_above;
        end
    end

    // Select nibble, decimal point, blank flag and one-hot enable for the current index.
    always_comb begin
        w_nibble    = '0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_an        = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_idx == IW'(i)) begin
                w_nibble    = r_data[4*i +: 4];
                w_dp_sel    = r_dp[i];
                w_blank_sel = r_blank[i] | w_suppress[i];
                w_an[i]     = 1'b1;
            end
        end
    end

    seg7_decoder u_decoder (
        .i_nibble (w_nibble),
        .i_mode   (mode),
        .o_seg    (w_seg)
    );

    // Output registers; a blank slot drives everything inactive.
    always_ff @(posedge clk) begin
        if (rst || w_blank_sel) begin
            r_seg    <= SEG_OFF ^ {7{INV}};
            r_dp_out <= INV;
            r_an     <= {N_DIGITS{INV}};
        end else begin
            r_seg    <= w_seg ^ {7{INV}};
            r_dp_out <= w_dp_sel ^ INV;
            r_an     <= w_an ^ {N_DIGITS{INV}};
        end
    end

    assign seg = r_seg;
    assign dp  = r_dp_out;
    assign an  = r_an;

endmodule
